// File: rtl/idct2d_ctrl_if.sv
// Stream and 1-D core bundle for the 2-D IDCT sequencer.
// slave = sequencer view, master = surrounding logic view.
interface idct2d_ctrl_if #(
  parameter int COEF_WIDTH = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [7:0][COEF_WIDTH-1:0] in_row;
  logic                       out_valid;
  logic                       out_ready;
  logic [7:0][COEF_WIDTH-1:0] out_row;
  logic                       idct_en;
  logic                       idct_locked;
  logic [7:0][COEF_WIDTH-1:0] idct_din;
  logic [7:0][COEF_WIDTH-1:0] idct_dout;
  logic                       busy;
  logic                       done;

  modport slave (
    input  in_valid, in_row, out_ready, idct_dout,
    output in_ready, out_valid, out_row, idct_en, idct_locked, idct_din, busy, done
  );

  modport master (
    output in_valid, in_row, out_ready, idct_dout,
    input  in_ready, out_valid, out_row, idct_en, idct_locked, idct_din, busy, done
  );
endinterface

// File: rtl/idct2d_ctrl.sv
// 2-D 8x8 inverse DCT sequencer: row pass and column pass through one shared
// 1-D core, with a single in-place transpose buffer between passes.
module idct2d_ctrl #(
  parameter int COEF_WIDTH   = 32,
  parameter int IDCT_LATENCY = 5
) (
  input logic           aclk,
  input logic           aresetn,
  idct2d_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;   // rows accepted / column index / output row
  logic [2:0]              cap_q, cap_d;   // destination of next core result
  logic [IDCT_LATENCY-1:0] tag_q, tag_d;   // one bit per real beat in flight in the core
  logic                    en_q, en_d;
  logic                    rdy_q, rdy_d;
  logic                    in_acc, out_acc, beat, cap, done_c;

  logic [COEF_WIDTH-1:0]      tbuf_q [8][8];
  logic [7:0][COEF_WIDTH-1:0] col_sel, out_sel;

  // Next state, counters, result tags and handshake decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    done_c  = 1'b0;
    in_acc  = (state_q == ROW) && rdy_q && bus.in_valid;
    out_acc = (state_q == OUT) && bus.out_ready;
    beat    = in_acc || (state_q == COL);
    cap     = tag_q[IDCT_LATENCY-1];
    tag_d   = {tag_q[IDCT_LATENCY-2:0], beat};
    if (cap) cap_d = cap_q + 3'd1;
    case (state_q)
      IDLE:      if (bus.in_valid) state_d = ROW;
      ROW: begin
        if (in_acc) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ROW_DRAIN;
        end
      end
      ROW_DRAIN: if (cap && cap_q == 3'd7) state_d = COL;
      COL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = COL_DRAIN;
      end
      COL_DRAIN: if (cap && cap_q == 3'd7) state_d = OUT;
      OUT: begin
        if (out_acc) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
    // Core enable rises with entry to ROW, one cycle ahead of the first row beat
    en_d  = (state_d == ROW) || (state_d == ROW_DRAIN) ||
            (state_d == COL) || (state_d == COL_DRAIN);
    // No acceptance in the first ROW cycle; drops on the 8th acceptance
    rdy_d = (state_q == ROW) && (state_d == ROW);
  end

  // Control registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      tag_q   <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      tag_q   <= tag_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  // Column and row views of the transpose buffer at the current index
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      col_sel[i] = tbuf_q[i][cnt_q];
      out_sel[i] = tbuf_q[cnt_q][i];
    end
  end

  // Capture tagged core results: rows during the row pass, columns afterwards
  always_ff @(posedge aclk) begin
    if (cap) begin
      if (state_q == COL || state_q == COL_DRAIN) begin
        for (int r = 0; r < 8; r++) tbuf_q[r][cap_q] <= bus.idct_dout[r];
      end else begin
        for (int c = 0; c < 8; c++) tbuf_q[cap_q][c] <= bus.idct_dout[c];
      end
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.idct_en     = en_q;
  assign bus.idct_locked = 1'b0;
  assign bus.idct_din    = in_acc ? bus.in_row : ((state_q == COL) ? col_sel : '0);
  assign bus.out_valid   = (state_q == OUT);
  assign bus.out_row     = (state_q == OUT) ? out_sel : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_c;

endmodule

// File: tb/tb_idct2d_ctrl.sv
// Bench for idct2d_ctrl: a 5-cycle integer 1-D IDCT core model, a 2-D
// reference built from plain row/column passes, and a per-cycle output monitor.
module tb_idct2d_ctrl;
  typedef logic [7:0][31:0] row_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;

  idct2d_ctrl_if #(.COEF_WIDTH(32)) bus ();

  idct2d_ctrl #(.COEF_WIDTH(32), .IDCT_LATENCY(5)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;
  always_ff @(posedge aclk) cyc <= cyc + 1;

  // cos(m*pi/16) scaled by 256
  function automatic longint cosv(input int m);
    longint base [9];
    int mm;
    base = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
    mm = m % 32;
    if (mm <= 8)       return base[mm];
    else if (mm <= 16) return -base[16-mm];
    else if (mm <= 24) return -base[mm-16];
    else               return base[32-mm];
  endfunction

  // Integer 8-point 1-D IDCT: out[i] = floor(sum_k s_k*cos((2i+1)k*pi/16)*x[k] / 512)
  function automatic row_t f1d(input row_t x);
    row_t   y;
    longint acc;
    for (int i = 0; i < 8; i++) begin
      acc = 181 * longint'($signed(x[0]));
      for (int k = 1; k < 8; k++) acc += cosv((2*i+1)*k) * longint'($signed(x[k]));
      acc = acc >>> 9;
      y[i] = acc[31:0];
    end
    return y;
  endfunction

  // 1-D core model with a 5-cycle pipeline, advancing while enabled
  row_t pipe [5];
  always_ff @(posedge aclk) begin
    if (bus.idct_en) begin
      pipe[0] <= f1d(bus.idct_din);
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.idct_dout = pipe[4];

  task automatic chk(input bit ok, input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: row pass, transpose, column pass; expected rows queued in order
  row_t exp_q [$];
  task automatic push_block(input row_t rows [8]);
    row_t r1 [8];
    row_t col, y;
    row_t res [8];
    for (int k = 0; k < 8; k++) r1[k] = f1d(rows[k]);
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) col[k] = r1[k][c];
      y = f1d(col);
      for (int r = 0; r < 8; r++) res[r][c] = y[r];
    end
    for (int r = 0; r < 8; r++) exp_q.push_back(res[r]);
  endtask

  // Monitor state
  int   nacc = 0, acc_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  bit   blk_open = 0, stall_prev = 0;
  row_t stall_row;
  row_t last_rows [8];

  initial begin
    row_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        nacc = 0; acc_cnt = 0; blk_open = 0; stall_prev = 0;
      end else begin
        if (stall_prev)
          chk(bus.out_valid && bus.out_row == stall_row, "out_hold", bus.out_row, stall_row);
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_row  = bus.out_row;
        chk(bus.idct_locked == 1'b0, "idct_locked", bus.idct_locked, 0);
        if (blk_open) chk(bus.in_ready == 1'b0, "in_ready_block_open", bus.in_ready, 0);
        if (bus.in_valid && bus.in_ready) begin
          acc_cnt++;
          if (acc_cnt == 8) begin acc_cnt = 0; blk_open = 1; end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "out_extra_row", bus.out_row, 0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.out_row == e, "out_row", bus.out_row, e);
          end
          last_rows[nacc] = bus.out_row;
          chk(bus.done == (nacc == 7), "done", bus.done, (nacc == 7));
          if (nacc == 7) begin
            done_cnt++; last_done_cyc = cyc; blk_open = 0; nacc = 0;
          end else nacc++;
        end else begin
          chk(bus.done == 1'b0, "done_spurious", bus.done, 0);
        end
      end
    end
  end

  // out_ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = pat[3 - (idx % 4)]; idx++; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_block(input row_t rows [8], input int gmode, output int t_first);
    int k, n;
    bit ph, seen;
    k = 0; n = 0; ph = 1; seen = 0; t_first = 0;
    while (k < 8 && n < 500) begin
      case (gmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = ph;
        default: bus.in_valid = ($urandom_range(0, 2) != 0);
      endcase
      ph = !ph;
      bus.in_row = rows[k];
      if (bus.in_valid && !seen) begin seen = 1; t_first = cyc; end
      @(negedge aclk);
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge aclk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    chk(k == 8, "in_accept_timeout", k, 8);
  endtask

  task automatic wait_blocks(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge aclk); n++; end
    chk(done_cnt >= target, "done_timeout", done_cnt, target);
  endtask

  task automatic check_all(input int v, input string name);
    bit ok;
    logic [255:0] got;
    ok = 1; got = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (last_rows[r][c] != 32'(v) && ok) begin ok = 0; got = last_rows[r]; end
    chk(ok, name, got, v);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(!bus.out_valid && !bus.in_ready && !bus.busy && !bus.done && !bus.idct_en,
        name, {bus.out_valid, bus.in_ready, bus.busy, bus.done, bus.idct_en}, 0);
    chk(bus.idct_din == '0 && bus.out_row == '0, {name, "_data"}, bus.idct_din | bus.out_row, 0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    row_t zero_blk [8];
    row_t dc_blk [8];
    row_t rnd_blk [8];
    row_t tmp;
    int   t0, tgt;
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t zero_blk [8];
    row_t dc_blk [8];
    row_t rnd_blk [8];
    row_t tmp;
    int   t0, tgt;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    for (int r = 0; r < 8; r++) begin zero_blk[r] = '0; dc_blk[r] = '0; end
    dc_blk[0][0] = 32'd64;

    @(posedge aclk); #1;
    do_reset();

    // Pin the reference core on the DC case: 64 -> 22 everywhere, 22 -> 7 everywhere
    tmp = f1d(dc_blk[0]);
    chk(tmp == {8{32'd22}}, "model_dc_row", tmp, {8{32'd22}});
    tmp = '0; tmp[0] = 32'd22;
    tmp = f1d(tmp);
    chk(tmp == {8{32'd7}}, "model_dc_col", tmp, {8{32'd7}});

    // Zero block, back-to-back, with the best-case schedule
    rdy_mode = 0;
    tgt = done_cnt + 1;
    push_block(zero_blk);
    send_block(zero_blk, 0, t0);
    wait_blocks(tgt);
    chk(last_done_cyc - t0 == 35, "done_latency", last_done_cyc - t0, 35);
    check_all(0, "zero_block");
    @(posedge aclk); #1;
    chk(bus.busy == 1'b0, "idle_after_done", bus.busy, 0);

    // DC block
    tgt = done_cnt + 1;
    push_block(dc_blk);
    send_block(dc_blk, 0, t0);
    wait_blocks(tgt);
    check_all(7, "dc_block");

    // DC block with alternating input gaps
    tgt = done_cnt + 1;
    push_block(dc_blk);
    send_block(dc_blk, 1, t0);
    wait_blocks(tgt);
    check_all(7, "dc_gaps");

    // DC block with downstream stalls
    rdy_mode = 1;
    tgt = done_cnt + 1;
    push_block(dc_blk);
    send_block(dc_blk, 0, t0);
    wait_blocks(tgt);
    repeat (20) @(posedge aclk);
    chk(done_cnt == tgt, "done_once", done_cnt, tgt);
    check_all(7, "dc_stall");
    rdy_mode = 0;

    // Reset in the middle of the column pass (column 3)
    push_block(dc_blk);
    send_block(dc_blk, 0, t0);
    repeat (8) @(posedge aclk);
    #2;
    chk(bus.busy && bus.idct_en && bus.idct_din[0] == 32'd22, "col3_before_reset",
        {bus.busy, bus.idct_en, bus.idct_din[0]}, {1'b1, 1'b1, 32'd22});
    do_reset();
    tgt = done_cnt + 1;
    push_block(dc_blk);
    send_block(dc_blk, 0, t0);
    wait_blocks(tgt);
    check_all(7, "dc_after_reset");

    // Two DC blocks offered back-to-back
    tgt = done_cnt + 2;
    push_block(dc_blk);
    push_block(dc_blk);
    send_block(dc_blk, 0, t0);
    send_block(dc_blk, 0, t0);
    wait_blocks(tgt);
    check_all(7, "dc_second_block");

    // Randomised blocks, gaps and stalls
    rdy_mode = 2;
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          rnd_blk[r][c] = 32'($urandom_range(0, 2000)) - 32'd1000;
      tgt = done_cnt + 1;
      push_block(rnd_blk);
      send_block(rnd_blk, 2, t0);
      wait_blocks(tgt);
    end
    rdy_mode = 0;

    repeat (10) @(posedge aclk);
    chk(exp_q.size() == 0, "rows_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
